// File: rtl/ram8_if.sv
// ram8 bus: write data, load strobe, word address and read data.
// master drives in/load/address, slave returns out.
interface ram8_if;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic [15:0] out;

  modport master (
    output in,
    output load,
    output address,
    input  out
  );

  modport slave (
    input  in,
    input  load,
    input  address,
    output out
  );
endinterface

// File: rtl/ram8.sv
// ram8: 8 x 16-bit memory built as dmux8way -> register16 x8 -> mux8way16.
// Ports: clk, reset (sync, active-high), bus (ram8_if.slave).

module ram8_dmux (
  input  logic in,
  input  logic sel,
  output logic a,
  output logic b
);
  assign a = in & ~sel;
  assign b = in & sel;
endmodule

module ram8_dmux4way (
  input  logic       in,
  input  logic [1:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d
);
  logic lo;
  logic hi;

  ram8_dmux u_top (.in(in), .sel(sel[1]), .a(lo), .b(hi));
  ram8_dmux u_lo  (.in(lo), .sel(sel[0]), .a(a),  .b(b));
  ram8_dmux u_hi  (.in(hi), .sel(sel[0]), .a(c),  .b(d));
endmodule

module ram8_dmux8way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic       l0,
  output logic       l1,
  output logic       l2,
  output logic       l3,
  output logic       l4,
  output logic       l5,
  output logic       l6,
  output logic       l7
);
  logic lo;
  logic hi;

  ram8_dmux u_top (.in(in), .sel(sel[2]), .a(lo), .b(hi));

  ram8_dmux4way u_lo (
    .in(lo), .sel(sel[1:0]),
    .a(l0), .b(l1), .c(l2), .d(l3)
  );

  ram8_dmux4way u_hi (
    .in(hi), .sel(sel[1:0]),
    .a(l4), .b(l5), .c(l6), .d(l7)
  );
endmodule

module ram8_register16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] d,
  output logic [15:0] q
);
  // reset wins over load, so a write in a reset cycle is dropped
  always_ff @(posedge clk) begin
    if (reset)
      q <= 16'h0000;
    else if (load)
      q <= d;
  end
endmodule

module ram8_mux16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sel,
  output logic [15:0] out
);
  assign out = sel ? b : a;
endmodule

module ram8_mux4way16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [1:0]  sel,
  output logic [15:0] out
);
  logic [15:0] ab;
  logic [15:0] cd;

  ram8_mux16 u_ab (.a(a),  .b(b),  .sel(sel[0]), .out(ab));
  ram8_mux16 u_cd (.a(c),  .b(d),  .sel(sel[0]), .out(cd));
  ram8_mux16 u_o  (.a(ab), .b(cd), .sel(sel[1]), .out(out));
endmodule

module ram8_mux8way16 (
  input  logic [15:0] w0,
  input  logic [15:0] w1,
  input  logic [15:0] w2,
  input  logic [15:0] w3,
  input  logic [15:0] w4,
  input  logic [15:0] w5,
  input  logic [15:0] w6,
  input  logic [15:0] w7,
  input  logic [2:0]  sel,
  output logic [15:0] out
);
  logic [15:0] lo;
  logic [15:0] hi;

  ram8_mux4way16 u_lo (
    .a(w0), .b(w1), .c(w2), .d(w3),
    .sel(sel[1:0]), .out(lo)
  );

  ram8_mux4way16 u_hi (
    .a(w4), .b(w5), .c(w6), .d(w7),
    .sel(sel[1:0]), .out(hi)
  );

  ram8_mux16 u_o (.a(lo), .b(hi), .sel(sel[2]), .out(out));
endmodule

module ram8 (
  input  logic  clk,
  input  logic  reset,
  ram8_if.slave bus
);
  logic l0, l1, l2, l3, l4, l5, l6, l7;
  logic [15:0] w0, w1, w2, w3, w4, w5, w6, w7;

  ram8_dmux8way u_dmux (
    .in(bus.load), .sel(bus.address),
    .l0(l0), .l1(l1), .l2(l2), .l3(l3),
    .l4(l4), .l5(l5), .l6(l6), .l7(l7)
  );

  ram8_register16 u_w0 (
    .clk(clk), .reset(reset), .load(l0), .d(bus.in), .q(w0)
  );
  ram8_register16 u_w1 (
    .clk(clk), .reset(reset), .load(l1), .d(bus.in), .q(w1)
  );
  ram8_register16 u_w2 (
    .clk(clk), .reset(reset), .load(l2), .d(bus.in), .q(w2)
  );
  ram8_register16 u_w3 (
    .clk(clk), .reset(reset), .load(l3), .d(bus.in), .q(w3)
  );
  ram8_register16 u_w4 (
    .clk(clk), .reset(reset), .load(l4), .d(bus.in), .q(w4)
  );
  ram8_register16 u_w5 (
    .clk(clk), .reset(reset), .load(l5), .d(bus.in), .q(w5)
  );
  ram8_register16 u_w6 (
    .clk(clk), .reset(reset), .load(l6), .d(bus.in), .q(w6)
  );
  ram8_register16 u_w7 (
    .clk(clk), .reset(reset), .load(l7), .d(bus.in), .q(w7)
  );

  ram8_mux8way16 u_mux (
    .w0(w0), .w1(w1), .w2(w2), .w3(w3),
    .w4(w4), .w5(w5), .w6(w6), .w7(w7),
    .sel(bus.address), .out(bus.out)
  );
endmodule

// File: tb/tb_ram8.sv
// Directed bench for ram8: reset, write/readback, read-during-write,
// load gating, reset priority, address edges, back-to-back writes.
module tb_ram8;
  logic clk;
  logic reset;
  int   nchk;
  int   npass;
  logic [15:0] mem [8];

  ram8_if bus ();

  ram8 dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    nchk++;
    if (got === exp)
      npass++;
    else
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int k, input logic [15:0] d);
    bus.address = 3'(k);
    bus.in      = d;
    bus.load    = 1'b1;
    tick();
    bus.load    = 1'b0;
    mem[k]      = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) mem[k] = 16'h0000;
  endtask

  task automatic sweep(input string tag);
    for (int k = 0; k < 8; k++) begin
      bus.address = 3'(k);
      #1;
      chk($sformatf("%s[%0d]", tag, k), bus.out, mem[k]);
    end
  endtask

  initial begin
    nchk        = 0;
    npass       = 0;
    reset       = 1'b0;
    bus.load    = 1'b0;
    bus.in      = 16'h0000;
    bus.address = 3'd0;
    tick();

    // fill with ones, then a single reset pulse clears all
    for (int k = 0; k < 8; k++) wr(k, 16'hFFFF);
    sweep("fill");
    do_reset();
    sweep("rst_clear");

    // extreme addresses, bit-exact patterns
    wr(0, 16'h8001);
    wr(7, 16'h7FFE);
    sweep("addr_edge");

    // distinct word per address, no aliasing
    for (int k = 0; k < 8; k++) begin
      logic [15:0] v;
      v = 16'(16'h1111 * (k + 1));
      wr(k, v);
    end
    sweep("wr_rd");
    bus.address = 3'd7;
    #1;
    chk("lit_7", bus.out, 16'h8888);

    // read-during-write returns old data until the edge
    wr(3, 16'hAAAA);
    bus.address = 3'd3;
    bus.in      = 16'h5555;
    bus.load    = 1'b1;
    #1;
    chk("rdw_before", bus.out, 16'hAAAA);
    tick();
    bus.load = 1'b0;
    mem[3]   = 16'h5555;
    chk("rdw_after", bus.out, 16'h5555);

    // load low: nothing changes; a glitch between edges is ignored
    bus.in = 16'hDEAD;
    for (int k = 0; k < 8; k++) begin
      bus.address = 3'(k);
      #2;
      bus.load = 1'b1;
      #1;
      bus.load = 1'b0;
      tick();
    end
    sweep("gate");

    // back-to-back writes to one address: last wins
    bus.address = 3'd2;
    bus.load    = 1'b1;
    bus.in      = 16'h0F0F;
    tick();
    bus.in      = 16'hF0F0;
    tick();
    bus.load    = 1'b0;
    mem[2]      = 16'hF0F0;
    sweep("b2b");

    // reset beats a simultaneous write
    reset       = 1'b1;
    bus.load    = 1'b1;
    bus.address = 3'd7;
    bus.in      = 16'h1234;
    tick();
    reset    = 1'b0;
    bus.load = 1'b0;
    for (int k = 0; k < 8; k++) mem[k] = 16'h0000;
    chk("rst_prio_7", bus.out, 16'h0000);
    sweep("rst_prio");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
